// File: rtl/sev_seg_page_sched_if.sv
// Signal bundle between the page scheduler and its surroundings: page sources,
// user controls, the alert handshake and the seven-segment driver outputs.
interface sev_seg_page_sched_if;
    logic [15:0] src0_data;
    logic [15:0] src1_data;
    logic [15:0] src2_data;
    logic [15:0] src3_data;
    logic [3:0]  src_valid;
    logic        auto_en;
    logic        btn_next;
    logic        alert_req;
    logic [15:0] alert_data;
    logic        alert_ack;
    logic [15:0] disp_data;
    logic        disp_shadow_zero;
    logic        disp_blank;
    logic [1:0]  page_idx;
    logic        alert_active;

    modport master (
        output src0_data, src1_data, src2_data, src3_data, src_valid,
        output auto_en, btn_next, alert_req, alert_data,
        input  alert_ack, disp_data, disp_shadow_zero, disp_blank,
        input  page_idx, alert_active
    );

    modport slave (
        input  src0_data, src1_data, src2_data, src3_data, src_valid,
        input  auto_en, btn_next, alert_req, alert_data,
        output alert_ack, disp_data, disp_shadow_zero, disp_blank,
        output page_idx, alert_active
    );
endinterface

// File: rtl/sev_seg_page_sched.sv
// Page scheduler for a 4-digit seven-segment display: rotates through valid pages
// and pre-empts them with timed alerts. Define SEVSEG_ALERT_BLINK_EN to blink alerts.
module sev_seg_page_sched #(
    parameter int unsigned DWELL_CYCLES = 50_000_000,
    parameter int unsigned ALERT_CYCLES = 100_000_000,
    parameter int unsigned BLINK_CYCLES = 12_500_000
) (
    input logic                 sys_clk,
    input logic                 sys_rst,
    sev_seg_page_sched_if.slave bus
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        SHOW    = 2'd1,
        ADVANCE = 2'd2,
        ALERT   = 2'd3
    } state_t;

    localparam logic [31:0] DWELL_LAST = 32'(DWELL_CYCLES - 1);
    localparam logic [31:0] ALERT_LAST = 32'(ALERT_CYCLES - 1);

    if (DWELL_CYCLES < 1 || ALERT_CYCLES < 1 || BLINK_CYCLES < 1) begin : g_param_check
        $error("sev_seg_page_sched: cycle parameters must be at least 1");
    end

    state_t      state_reg, state_next;
    logic [1:0]  page_reg, page_next;
    logic [31:0] dwell_reg, dwell_next;
    logic [31:0] alert_cnt_reg, alert_cnt_next;
    logic [15:0] alert_latch_reg, alert_latch_next;
    logic [15:0] disp_reg, disp_next;
    logic        shadow_reg, shadow_next;
    logic        blank_reg, blank_next;
    logic        ack_reg, ack_next;
    logic        active_reg, active_next;
`ifdef SEVSEG_ALERT_BLINK_EN
    localparam logic [31:0] BLINK_LAST = 32'(BLINK_CYCLES - 1);
    logic [31:0] blink_cnt_reg, blink_cnt_next;
`endif

    logic [15:0] src_arr [4];
    logic [1:0]  cand_idx [4];
    logic [3:0]  cand_ok;
    logic [1:0]  sel_idx;
    logic        any_valid;
    logic        take_alert;
    logic        leave_show;

    assign src_arr[0] = bus.src0_data;
    assign src_arr[1] = bus.src1_data;
    assign src_arr[2] = bus.src2_data;
    assign src_arr[3] = bus.src3_data;

    // Candidate gi is gi+1 pages after the current one; the last wraps back onto
    // the current page so a lone valid page is re-selected.
    for (genvar gi = 0; gi < 4; gi++) begin : g_cand
        assign cand_idx[gi] = page_reg + 2'(gi + 1);
        assign cand_ok[gi]  = bus.src_valid[cand_idx[gi]];
    end

    always_comb begin
        sel_idx = page_reg;
        for (int i = 3; i >= 0; i--) begin
            if (cand_ok[i]) begin
                sel_idx = cand_idx[i];
            end
        end
    end

    assign any_valid  = |bus.src_valid;
    assign take_alert = bus.alert_req && (state_reg == SHOW || state_reg == ADVANCE);
    assign leave_show = bus.btn_next || !bus.src_valid[page_reg] ||
                        (bus.auto_en && dwell_reg == DWELL_LAST);

    always_ff @(posedge sys_clk) begin
        if (sys_rst) begin
            state_reg       <= IDLE;
            page_reg        <= 2'd3;
            dwell_reg       <= '0;
            alert_cnt_reg   <= '0;
            alert_latch_reg <= '0;
            disp_reg        <= '0;
            shadow_reg      <= 1'b1;
            blank_reg       <= 1'b1;
            ack_reg         <= 1'b0;
            active_reg      <= 1'b0;
`ifdef SEVSEG_ALERT_BLINK_EN
            blink_cnt_reg   <= '0;
`endif
        end else begin
            state_reg       <= state_next;
            page_reg        <= page_next;
            dwell_reg       <= dwell_next;
            alert_cnt_reg   <= alert_cnt_next;
            alert_latch_reg <= alert_latch_next;
            disp_reg        <= disp_next;
            shadow_reg      <= shadow_next;
            blank_reg       <= blank_next;
            ack_reg         <= ack_next;
            active_reg      <= active_next;
`ifdef SEVSEG_ALERT_BLINK_EN
            blink_cnt_reg   <= blink_cnt_next;
`endif
        end
    end

    // Outputs are computed for the state being entered, so they are registered
    // alongside it and never lag the FSM by a cycle.
    always_comb begin
        state_next       = state_reg;
        page_next        = page_reg;
        dwell_next       = dwell_reg;
        alert_cnt_next   = alert_cnt_reg;
        alert_latch_next = alert_latch_reg;
        disp_next        = disp_reg;
        shadow_next      = 1'b1;
        blank_next       = 1'b0;
        ack_next         = 1'b0;
        active_next      = 1'b0;
`ifdef SEVSEG_ALERT_BLINK_EN
        blink_cnt_next   = blink_cnt_reg;
`endif
        if (take_alert) begin
            state_next       = ALERT;
            alert_latch_next = bus.alert_data;
            alert_cnt_next   = '0;
            disp_next        = bus.alert_data;
            shadow_next      = 1'b0;
            ack_next         = 1'b1;
            active_next      = 1'b1;
`ifdef SEVSEG_ALERT_BLINK_EN
            blink_cnt_next   = '0;
`endif
        end else begin
            case (state_reg)
                IDLE: begin
                    state_next = ADVANCE;
                    disp_next  = '0;
                    blank_next = 1'b1;
                end
                ADVANCE: begin
                    if (!any_valid) begin
                        disp_next  = '0;
                        blank_next = 1'b1;
                    end else begin
                        state_next = SHOW;
                        page_next  = sel_idx;
                        dwell_next = '0;
                        disp_next  = src_arr[sel_idx];
                    end
                end
                SHOW: begin
                    disp_next = src_arr[page_reg];
                    if (leave_show) begin
                        state_next = ADVANCE;
                        dwell_next = '0;
                    end else if (bus.auto_en) begin
                        dwell_next = dwell_reg + 32'd1;
                    end
                end
                ALERT: begin
                    if (alert_cnt_reg == ALERT_LAST) begin
                        state_next     = SHOW;
                        alert_cnt_next = '0;
                        dwell_next     = '0;
                        disp_next      = src_arr[page_reg];
                    end else begin
                        alert_cnt_next = alert_cnt_reg + 32'd1;
                        disp_next      = alert_latch_reg;
                        shadow_next    = 1'b0;
                        active_next    = 1'b1;
`ifdef SEVSEG_ALERT_BLINK_EN
                        if (blink_cnt_reg == BLINK_LAST) begin
                            blink_cnt_next = '0;
                            blank_next     = ~blank_reg;
                        end else begin
                            blink_cnt_next = blink_cnt_reg + 32'd1;
                            blank_next     = blank_reg;
                        end
`endif
                    end
                end
                default: begin
                    state_next = IDLE;
                end
            endcase
        end
    end

    assign bus.disp_data        = disp_reg;
    assign bus.disp_shadow_zero = shadow_reg;
    assign bus.disp_blank       = blank_reg;
    assign bus.alert_ack        = ack_reg;
    assign bus.alert_active     = active_reg;
    assign bus.page_idx         = page_reg;

endmodule

// File: tb/tb_sev_seg_page_sched.sv
// Randomised phases checked every cycle against a behavioural model of the
// page scheduler (page rotation, skipping, manual advance, alerts, empty set, reset).
module tb_sev_seg_page_sched;

    localparam int DW = 8;
    localparam int AC = 6;
    localparam int BC = 2;

    localparam int M_IDLE  = 0;
    localparam int M_SHOW  = 1;
    localparam int M_ADV   = 2;
    localparam int M_ALERT = 3;

    logic sys_clk = 1'b0;
    logic sys_rst = 1'b1;

    sev_seg_page_sched_if bus ();

    sev_seg_page_sched #(
        .DWELL_CYCLES(DW),
        .ALERT_CYCLES(AC),
        .BLINK_CYCLES(BC)
    ) dut (
        .sys_clk(sys_clk),
        .sys_rst(sys_rst),
        .bus    (bus)
    );

    always #5 sys_clk = ~sys_clk;

    int n_tests = 0;
    int n_fail  = 0;

    // Model state
    int          m_mode;
    int          m_page;
    int          m_shown;
    int          m_left;
    logic [15:0] m_alert_val;
    logic [15:0] e_disp;
    logic        e_shadow, e_blank, e_ack, e_active;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic [15:0] src_val(input int p);
        case (p)
            0:       return bus.src0_data;
            1:       return bus.src1_data;
            2:       return bus.src2_data;
            default: return bus.src3_data;
        endcase
    endfunction

    task automatic model_step();
        logic [3:0] v;
        int nxt;
        v = bus.src_valid;
        e_ack = 1'b0;
        if (sys_rst) begin
            m_mode = M_IDLE; m_page = 3; m_shown = 0; m_left = 0;
            e_disp = 16'h0000; e_shadow = 1'b1; e_blank = 1'b1; e_active = 1'b0;
            return;
        end
        if ((m_mode == M_SHOW || m_mode == M_ADV) && bus.alert_req) begin
            m_mode = M_ALERT; m_left = AC; m_alert_val = bus.alert_data;
            e_disp = bus.alert_data; e_shadow = 1'b0; e_blank = 1'b0;
            e_ack = 1'b1; e_active = 1'b1;
            $display("[TB] alert accepted value=%h on page %0d", bus.alert_data, m_page);
            return;
        end
        case (m_mode)
            M_IDLE: begin
                m_mode = M_ADV;
                e_disp = 16'h0000; e_blank = 1'b1; e_shadow = 1'b1; e_active = 1'b0;
            end
            M_ADV: begin
                if (v == 4'b0000) begin
                    e_disp = 16'h0000; e_blank = 1'b1; e_shadow = 1'b1;
                end else begin
                    nxt = m_page;
                    for (int k = 1; k <= 4; k++) begin
                        if (v[(m_page + k) % 4]) begin
                            nxt = (m_page + k) % 4;
                            break;
                        end
                    end
                    m_page = nxt; m_mode = M_SHOW; m_shown = 0;
                    e_disp = src_val(nxt); e_blank = 1'b0; e_shadow = 1'b1;
                    $display("[TB] page -> %0d", nxt);
                end
            end
            M_SHOW: begin
                e_disp = src_val(m_page); e_blank = 1'b0; e_shadow = 1'b1; e_active = 1'b0;
                if (bus.btn_next || !v[m_page]) begin
                    m_mode = M_ADV;
                end else if (bus.auto_en) begin
                    m_shown++;
                    if (m_shown == DW) m_mode = M_ADV;
                end
            end
            default: begin
                m_left--;
                if (m_left == 0) begin
                    m_mode = M_SHOW; m_shown = 0;
                    e_disp = src_val(m_page); e_shadow = 1'b1; e_blank = 1'b0; e_active = 1'b0;
                end else begin
                    e_disp = m_alert_val; e_shadow = 1'b0; e_active = 1'b1;
`ifdef SEVSEG_ALERT_BLINK_EN
                    e_blank = (((AC - m_left) / BC) % 2) == 1;
`else
                    e_blank = 1'b0;
`endif
                end
            end
        endcase
    endtask

    task automatic step();
        @(posedge sys_clk);
        model_step();
        #1;
        check("disp_data",        32'(bus.disp_data),        32'(e_disp));
        check("disp_shadow_zero", 32'(bus.disp_shadow_zero), 32'(e_shadow));
        check("disp_blank",       32'(bus.disp_blank),       32'(e_blank));
        check("alert_ack",        32'(bus.alert_ack),        32'(e_ack));
        check("alert_active",     32'(bus.alert_active),     32'(e_active));
        check("page_idx",         32'(bus.page_idx),         32'(m_page));
    endtask

    task automatic drive(input int mode);
        @(negedge sys_clk);
        sys_rst       = 1'b0;
        bus.btn_next  = 1'b0;
        bus.alert_req = 1'b0;
        if ($urandom_range(2) == 0) begin
            case ($urandom_range(3))
                0:       bus.src0_data = 16'($urandom);
                1:       bus.src1_data = 16'($urandom);
                2:       bus.src2_data = 16'($urandom);
                default: bus.src3_data = 16'($urandom);
            endcase
        end
        case (mode)
            0: begin bus.src_valid = 4'b1111; bus.auto_en = 1'b1; end
            1: begin
                bus.src_valid = ($urandom_range(15) == 0) ? 4'b0001 : 4'b0101;
                bus.auto_en   = 1'b1;
            end
            2: begin
                bus.src_valid = 4'b1111; bus.auto_en = 1'b0;
                bus.btn_next  = ($urandom_range(19) == 0);
            end
            3: begin bus.src_valid = 4'b1111; bus.auto_en = 1'b0; end
            4, 7: begin
                bus.src_valid  = 4'b1111; bus.auto_en = 1'b1;
                bus.alert_req  = ($urandom_range(9) == 0);
                bus.alert_data = 16'hDEAD;
                bus.btn_next   = bus.alert_req || ($urandom_range(7) == 0);
                if (mode == 7 && m_mode == M_ALERT && $urandom_range(3) == 0) sys_rst = 1'b1;
            end
            5: begin bus.src_valid = 4'b0000; bus.auto_en = 1'b1; end
            6: begin bus.src_valid = 4'b0010; bus.auto_en = 1'b1; end
            default: begin
                bus.src_valid  = 4'($urandom);
                bus.auto_en    = ($urandom_range(3) != 0);
                bus.btn_next   = ($urandom_range(7) == 0);
                bus.alert_req  = ($urandom_range(11) == 0);
                bus.alert_data = 16'($urandom);
                sys_rst        = ($urandom_range(199) == 0);
            end
        endcase
    endtask

    int phase_mode [10] = '{0, 1, 2, 3, 2, 4, 5, 6, 7, 8};
    int phase_len  [10] = '{60, 80, 80, 120, 40, 150, 20, 20, 150, 600};

    initial begin
        bus.src0_data  = 16'h1111;
        bus.src1_data  = 16'h2222;
        bus.src2_data  = 16'h3333;
        bus.src3_data  = 16'h4444;
        bus.src_valid  = 4'b1111;
        bus.auto_en    = 1'b1;
        bus.btn_next   = 1'b0;
        bus.alert_req  = 1'b0;
        bus.alert_data = 16'h0000;
        sys_rst        = 1'b1;
        repeat (2) step();
        for (int p = 0; p < 10; p++) begin
            for (int c = 0; c < phase_len[p]; c++) begin
                drive(phase_mode[p]);
                step();
            end
        end
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
